conv_accum_array: RTL

//   Parametrised successor to the fixed 32-channel convolution array. Computes N_OC x N_OUT
//   K-tap 1-D dot products per beat over one shared pixel window. Accumulates them over

---
 rtl/conv_pkg.sv | 39 +++
 rtl/conv_dot_row.sv | 48 ++++
 rtl/conv_accum_array.sv | 123 ++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared widths, pipeline tags and bit-packing helpers
// for the convolution accumulator array.
package conv_pkg;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
        logic relu;
        logic sign;
    } s1_tag_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Width that holds a full K-tap dot product without overflow.
    function automatic int dot_w(input int data_w, input int taps);
        return 2 * data_w + clog2(taps);
    endfunction

    function automatic int img_off(input int i, input int data_w);
        return i * data_w;
    endfunction

    function automatic int wgt_off(input int n, input int k,
                                   input int taps, input int data_w);
        return (n * taps + k) * data_w;
    endfunction

    function automatic int psum_off(input int n, input int j,
                                    input int n_out, input int w);
        return (n * n_out + j) * w;
    endfunction

endpackage

// File: rtl/conv_dot_row.sv
// One output channel: N_OUT sliding K-tap dot products over
// the shared pixel window, purely combinational.
module conv_dot_row
    import conv_pkg::*;
#(
    parameter  int K      = 7,
    parameter  int N_OUT  = 4,
    parameter  int DATA_W = 8,
    localparam int IN_W   = K + N_OUT - 1,
    localparam int DOT_W  = dot_w(DATA_W, K)
) (
    input  logic                    sign_mode,
    input  logic [IN_W*DATA_W-1:0]  image,
    input  logic [K*DATA_W-1:0]     weight,
    output logic [N_OUT*DOT_W-1:0]  dot
);

    logic signed [DATA_W:0] px [IN_W];
    logic signed [DATA_W:0] wt [K];
    logic signed [DOT_W-1:0] s;

    function automatic logic signed [DATA_W:0] ext(
        input logic [DATA_W-1:0] x,
        input logic              sg
    );
        return $signed({sg & x[DATA_W-1], x});
    endfunction

    always_comb begin
        for (int i = 0; i < IN_W; i++)
            px[i] = ext(image[img_off(i, DATA_W) +: DATA_W], sign_mode);
        for (int k = 0; k < K; k++)
            wt[k] = ext(weight[img_off(k, DATA_W) +: DATA_W], sign_mode);
    end

    // Modulo-2^DOT_W arithmetic is exact: the true sum always fits.
    always_comb begin
        dot = '0;
        s   = '0;
        for (int j = 0; j < N_OUT; j++) begin
            s = '0;
            for (int k = 0; k < K; k++)
                s = s + DOT_W'(px[j+k]) * DOT_W'(wt[k]);
            dot[j*DOT_W +: DOT_W] = s;
        end
    end

endmodule

// File: rtl/conv_accum_array.sv
// N_OC x N_OUT dot products per beat, accumulated over input-channel
// beats, published on a valid/ready stream with optional ReLU.
module conv_accum_array
    import conv_pkg::*;
#(
    parameter  int N_OC   = 32,
    parameter  int K      = 7,
    parameter  int N_OUT  = 4,
    parameter  int DATA_W = 8,
    parameter  int ACC_W  = 32,
    localparam int IN_W   = K + N_OUT - 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_first,
    input  logic                          in_last,
    input  logic                          sign_mode,
    input  logic                          relu_en,
    input  logic [IN_W*DATA_W-1:0]        image,
    input  logic [N_OC*K*DATA_W-1:0]      weight,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_OC*N_OUT*ACC_W-1:0]   psum,
    output logic [7:0]                    out_nch
);

    localparam int DOT_W = dot_w(DATA_W, K);
    localparam int LANES = N_OC * N_OUT;

    logic                     advance;
    logic                     publish;
    logic [LANES*DOT_W-1:0]   dot_all;
    logic [LANES*DOT_W-1:0]   s1_dot;
    s1_tag_t                  s1;
    logic [LANES*ACC_W-1:0]   acc;
    logic [LANES*ACC_W-1:0]   acc_next;
    logic [LANES*ACC_W-1:0]   res;
    logic [7:0]               cnt;
    logic [7:0]               cnt_next;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign publish  = advance && s1.valid && s1.last;

    for (genvar n = 0; n < N_OC; n++) begin : g_row
        conv_dot_row #(
            .K      (K),
            .N_OUT  (N_OUT),
            .DATA_W (DATA_W)
        ) u_row (
            .sign_mode (sign_mode),
            .image     (image),
            .weight    (weight[wgt_off(n, 0, K, DATA_W) +: K*DATA_W]),
            .dot       (dot_all[psum_off(n, 0, N_OUT, DOT_W) +: N_OUT*DOT_W])
        );
    end

    function automatic logic [ACC_W-1:0] dext(
        input logic [DOT_W-1:0] d,
        input logic             sg
    );
        return sg ? ACC_W'($signed(d)) : ACC_W'(d);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= '0;
            s1_dot <= '0;
        end else if (advance) begin
            s1.valid <= in_valid;
            s1.first <= in_first;
            s1.last  <= in_last;
            s1.relu  <= relu_en;
            s1.sign  <= sign_mode;
            s1_dot   <= dot_all;
        end
    end

    always_comb begin
        acc_next = '0;
        res      = '0;
        for (int i = 0; i < LANES; i++) begin
            acc_next[i*ACC_W +: ACC_W] =
                (s1.first ? '0 : acc[i*ACC_W +: ACC_W])
                + dext(s1_dot[i*DOT_W +: DOT_W], s1.sign);
            res[i*ACC_W +: ACC_W] =
                (s1.relu && acc_next[i*ACC_W + ACC_W - 1])
                ? '0 : acc_next[i*ACC_W +: ACC_W];
        end
    end

    assign cnt_next = s1.first ? 8'd1
                    : (cnt == 8'hFF) ? 8'hFF : cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            psum      <= '0;
            out_nch   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (advance && s1.valid) begin
                if (s1.last) begin
                    psum    <= res;
                    out_nch <= cnt_next;
                    acc     <= '0;
                    cnt     <= '0;
                end else begin
                    acc <= acc_next;
                    cnt <= cnt_next;
                end
            end
            if (publish)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;
        end
    end

endmodule
